// File: rtl/ksa_scheduler_if.sv
// Handshake and S-memory bus between the RC4 key-scheduling stage and its surroundings.
// The master modport is the scheduler side. The slave modport is the memory/controller side.
interface ksa_scheduler_if #(
   parameter int KEY_BYTES = 3
);
   logic                   start;
   logic [8*KEY_BYTES-1:0] secret_key;
   logic [7:0]             s_q;
   logic [7:0]             s_address;
   logic [7:0]             s_data;
   logic                   s_wren;
   logic                   busy;
   logic                   done;

   modport master (
      input  start, secret_key, s_q,
      output s_address, s_data, s_wren, busy, done
   );

   modport slave (
      output start, secret_key, s_q,
      input  s_address, s_data, s_wren, busy, done
   );
endinterface

// File: rtl/ksa_scheduler.sv
// RC4 key-scheduling stage: permutes S-memory with the secret key, then holds done until start drops.
// Define SKA_INIT_EN to run the 256-cycle identity INIT phase before scheduling.
module ksa_scheduler #(
   parameter int KEY_BYTES = 3,
   parameter int READ_LAT  = 2
) (
   input  logic clk,
   input  logic reset,
   ksa_scheduler_if.master bus
);

   typedef enum logic [3:0] {
      IDLE, INIT, RD_I, CAP_I, RD_J, CAP_J, WR_J, WR_I, DONE
   } state_t;

   localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);
   localparam logic [2:0] KIDX_LAST = 3'(KEY_BYTES - 1);

   state_t                 r_state;
   logic [7:0]             r_i;
   logic [7:0]             r_j;
   logic [7:0]             r_si;
   logic [7:0]             r_sj;
   logic [2:0]             r_kidx;
   logic [1:0]             r_wait;
   logic [8*KEY_BYTES-1:0] r_key;
   logic [7:0]             r_addr;
   logic [7:0]             r_data;
   logic                   r_wren;
   logic                   r_busy;
   logic                   r_done;

   logic [7:0]             w_keyByte;
   logic [7:0]             w_jNext;

   // Byte 0 is the most significant byte of the latched key.
   always_comb begin
      w_keyByte = 8'h00;
      for (int k = 0; k < KEY_BYTES; k++) begin
         if (r_kidx == k[2:0]) begin
            w_keyByte = r_key[8*(KEY_BYTES-1-k) +: 8];
         end
      end
   end

   assign w_jNext = r_j + bus.s_q + w_keyByte;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_i     <= 8'h00;
         r_j     <= 8'h00;
         r_si    <= 8'h00;
         r_sj    <= 8'h00;
         r_kidx  <= 3'd0;
         r_wait  <= 2'd0;
         r_key   <= '0;
         r_addr  <= 8'h00;
         r_data  <= 8'h00;
         r_wren  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_key  <= bus.secret_key;
                  r_i    <= 8'h00;
                  r_j    <= 8'h00;
                  r_kidx <= 3'd0;
                  r_wait <= 2'd0;
                  r_addr <= 8'h00;
                  r_data <= 8'h00;
                  r_busy <= 1'b1;
                  r_done <= 1'b0;
`ifdef SKA_INIT_EN
                  r_wren  <= 1'b1;
                  r_state <= INIT;
`else
                  r_wren  <= 1'b0;
                  r_state <= RD_I;
`endif
               end
            end
            INIT: begin
               if (r_i == 8'hFF) begin
                  r_i     <= 8'h00;
                  r_addr  <= 8'h00;
                  r_data  <= 8'h00;
                  r_wren  <= 1'b0;
                  r_state <= RD_I;
               end else begin
                  r_i    <= r_i + 8'd1;
                  r_addr <= r_i + 8'd1;
                  r_data <= r_i + 8'd1;
               end
            end
            RD_I: begin
               if (r_wait == WAIT_LAST) begin
                  r_wait  <= 2'd0;
                  r_state <= CAP_I;
               end else begin
                  r_wait <= r_wait + 2'd1;
               end
            end
            CAP_I: begin
               r_si    <= bus.s_q;
               r_j     <= w_jNext;
               r_addr  <= w_jNext;
               r_state <= RD_J;
            end
            RD_J: begin
               if (r_wait == WAIT_LAST) begin
                  r_wait  <= 2'd0;
                  r_state <= CAP_J;
               end else begin
                  r_wait <= r_wait + 2'd1;
               end
            end
            CAP_J: begin
               r_sj    <= bus.s_q;
               r_addr  <= r_j;
               r_data  <= r_si;
               r_wren  <= 1'b1;
               r_state <= WR_J;
            end
            WR_J: begin
               r_addr  <= r_i;
               r_data  <= r_sj;
               r_state <= WR_I;
            end
            // When i == j both writes carry the same value to the same address, so no special case is needed.
            WR_I: begin
               r_wren <= 1'b0;
               if (r_i == 8'hFF) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_i     <= r_i + 8'd1;
                  r_addr  <= r_i + 8'd1;
                  r_kidx  <= (r_kidx == KIDX_LAST) ? 3'd0 : r_kidx + 3'd1;
                  r_state <= RD_I;
               end
            end
            DONE: begin
               if (!bus.start) begin
                  r_done  <= 1'b0;
                  r_addr  <= 8'h00;
                  r_data  <= 8'h00;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.s_address = r_addr;
   assign bus.s_data    = r_data;
   assign bus.s_wren    = r_wren;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_ksa_scheduler.sv
// Directed testbench for ksa_scheduler: behavioural synchronous RAM, write log and golden RC4 KSA.
// Works with or without SKA_INIT_EN defined.
module tb_ksa_scheduler;

`ifdef SKA_INIT_EN
   localparam int initWrites = 256;
`else
   localparam int initWrites = 0;
`endif
   localparam int expCycles = initWrites + 2049;
   localparam int expWrites = initWrites + 512;

   logic clk;
   logic reset;

   ksa_scheduler_if #(.KEY_BYTES(3)) bus ();

   ksa_scheduler #(.KEY_BYTES(3), .READ_LAT(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0] mem [256];
   logic [7:0] gold [256];
   logic [7:0] logAddr [4096];
   logic [7:0] logData [4096];
   int         wCount = 0;
   logic       preloadReq = 1'b0;
   int         totalChecks = 0;
   int         passedChecks = 0;
   int         logStart = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port RAM (read-before-write) plus a log of every committed write.
   always @(posedge clk) begin
      if (preloadReq) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
      end else if (bus.s_wren) begin
         mem[bus.s_address] <= bus.s_data;
      end
      bus.s_q <= mem[bus.s_address];
      if (bus.s_wren && !preloadReq && wCount < 4096) begin
         logAddr[wCount] <= bus.s_address;
         logData[wCount] <= bus.s_data;
         wCount          <= wCount + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual === expected) passedChecks++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
   endtask

   task automatic preloadIdentity();
      preloadReq = 1'b1;
      @(posedge clk); #1;
      preloadReq = 1'b0;
   endtask

   task automatic goldenKsa(input logic [23:0] key);
      logic [7:0] jj;
      logic [7:0] t;
      logic [7:0] kb [3];
      kb[0] = key[23:16];
      kb[1] = key[15:8];
      kb[2] = key[7:0];
      for (int k = 0; k < 256; k++) gold[k] = 8'(k);
      jj = 8'h00;
      for (int k = 0; k < 256; k++) begin
         jj = jj + gold[k] + kb[k % 3];
         t = gold[k];
         gold[k] = gold[jj];
         gold[jj] = t;
      end
   endtask

   task automatic applyStimulus(input logic [23:0] key);
      logStart = wCount;
      bus.secret_key = key;
      bus.start = 1'b1;
   endtask

   task automatic waitDone(output int cycles, output int busyLow);
      cycles = 0;
      busyLow = 0;
      for (int n = 0; n < 5000; n++) begin
         @(posedge clk); #1;
         cycles++;
         if (bus.done) break;
         if (!bus.busy) busyLow++;
      end
   endtask

   function automatic int goldMismatches();
      int bad = 0;
      for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) bad++;
      return bad;
   endfunction

   initial begin
      int cycles;
      int busyLow;
      int holdStart;
      int bad;

      reset = 1'b1;
      bus.start = 1'b0;
      bus.secret_key = 24'h0;
      #1;
      checkOutput("rstAddr", 32'(bus.s_address), 32'h0);
      checkOutput("rstData", 32'(bus.s_data), 32'h0);
      checkOutput("rstWren", 32'(bus.s_wren), 32'h0);
      checkOutput("rstBusy", 32'(bus.busy), 32'h0);
      checkOutput("rstDone", 32'(bus.done), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Full schedule with key 000249 and golden comparison.
      preloadIdentity();
      goldenKsa(24'h000249);
      applyStimulus(24'h000249);
      waitDone(cycles, busyLow);
      checkOutput("runA_done", 32'(bus.done), 32'h1);
      checkOutput("runA_cycles", 32'(cycles), 32'(expCycles));
      checkOutput("runA_writes", 32'(wCount - logStart), 32'(expWrites));
      checkOutput("runA_busyLow", 32'(busyLow), 32'h0);
      checkOutput("runA_golden", 32'(goldMismatches()), 32'h0);
`ifdef SKA_INIT_EN
      bad = 0;
      for (int k = 0; k < 256; k++)
         if (logAddr[logStart+k] !== 8'(k) || logData[logStart+k] !== 8'(k)) bad++;
      checkOutput("runA_initWrites", 32'(bad), 32'h0);
`endif

      // Holding start after done keeps DONE with no writes.
      holdStart = wCount;
      repeat (100) @(posedge clk);
      #1;
      checkOutput("hold_writes", 32'(wCount - holdStart), 32'h0);
      checkOutput("hold_done", 32'(bus.done), 32'h1);
      bus.start = 1'b0;
      @(posedge clk); #1;
      checkOutput("release_done", 32'(bus.done), 32'h0);
      checkOutput("release_busy", 32'(bus.busy), 32'h0);

      // Key 000000: first iteration has i == j == 0.
      preloadIdentity();
      goldenKsa(24'h000000);
      applyStimulus(24'h000000);
      waitDone(cycles, busyLow);
      checkOutput("runB_done", 32'(bus.done), 32'h1);
      checkOutput("runB_wrJAddr", 32'(logAddr[logStart+initWrites]), 32'h0);
      checkOutput("runB_wrJData", 32'(logData[logStart+initWrites]), 32'h0);
      checkOutput("runB_wrIAddr", 32'(logAddr[logStart+initWrites+1]), 32'h0);
      checkOutput("runB_wrIData", 32'(logData[logStart+initWrites+1]), 32'h0);
      checkOutput("runB_golden", 32'(goldMismatches()), 32'h0);
      bus.start = 1'b0;
      @(posedge clk); #1;

      // Key AABBCC: j sequence AA, 66, 34, E1 exposes the key-byte rotation.
      preloadIdentity();
      applyStimulus(24'hAABBCC);
      waitDone(cycles, busyLow);
      checkOutput("runC_j0", 32'(logAddr[logStart+initWrites+0]), 32'hAA);
      checkOutput("runC_j1", 32'(logAddr[logStart+initWrites+2]), 32'h66);
      checkOutput("runC_j2", 32'(logAddr[logStart+initWrites+4]), 32'h34);
      checkOutput("runC_j3", 32'(logAddr[logStart+initWrites+6]), 32'hE1);
      bus.start = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of iteration i=100, then relaunch from i=0.
      preloadIdentity();
      applyStimulus(24'h000000);
      for (int n = 0; n < 5000; n++) begin
         @(posedge clk); #1;
         if (wCount - logStart >= initWrites + 201) break;
      end
      checkOutput("midRun_wren", 32'(bus.s_wren), 32'h1);
      checkOutput("midRun_wrIAddr", 32'(bus.s_address), 32'd100);
      reset = 1'b1;
      #1;
      checkOutput("abort_wren", 32'(bus.s_wren), 32'h0);
      checkOutput("abort_busy", 32'(bus.busy), 32'h0);
      checkOutput("abort_addr", 32'(bus.s_address), 32'h0);
      bus.start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      checkOutput("restart_busy", 32'(bus.busy), 32'h1);
      checkOutput("restart_addr", 32'(bus.s_address), 32'h0);
      bus.start = 1'b0;

      $display("%0d/%0d checks passed", passedChecks, totalChecks);
      $finish;
   end

endmodule
